// File: rtl/and3_tp_pkg.sv
// Shared types and constants for the 3-input AND gate pattern checker.
// Imported by the checker top and its hold timer.
package and3_tp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } tp_state_e;

    localparam int NUM_PATTERNS    = 8;
    localparam int HOLD_CYCLES_DEF = 4;

    function automatic logic and3_ref(input logic [2:0] p);
        return &p;
    endfunction

endpackage

// File: rtl/and3_pattern_checker_if.sv
// Gate-facing bus: checker drives a/b/c, gate returns y.
// master = checker side, slave = gate side.
interface and3_pattern_checker_if;

    logic a_o;
    logic b_o;
    logic c_o;
    logic y_i;

    modport master (
        output a_o,
        output b_o,
        output c_o,
        input  y_i
    );

    modport slave (
        input  a_o,
        input  b_o,
        input  c_o,
        output y_i
    );

endinterface

// File: rtl/and3_pattern_checker_hold_timer.sv
// Hold counter: counts 0..HOLD_CYCLES-1 while enabled and pulses
// tc on the last count, then wraps to 0.
module hold_timer #(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    assign tc = en & (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || tc) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/and3_pattern_checker.sv
// Sweeps a/b/c of an AND3 gate through all 8 patterns, samples y
// after a hold period and records error count and first failure.
module and3_pattern_checker
    import and3_tp_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
    parameter int CNT_W       = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    and3_pattern_checker_if.master gate,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [3:0]             err_count,
    output logic                   fail_valid,
    output logic [2:0]             fail_pattern
);

    tp_state_e  state;
    tp_state_e  state_nx;
    logic [2:0] pattern;
    logic [2:0] drive;
    logic [3:0] err_nx;
    logic       accept;
    logic       last;
    logic       mismatch;
    logic       tc;
    logic       tmr_clr;
    logic       tmr_en;

    assign accept   = start & ((state == IDLE) | (state == DONE));
    assign last     = (pattern == 3'(NUM_PATTERNS - 1));
    // y is only looked at in SAMPLE, so an X from the gate elsewhere is harmless
    assign mismatch = (state == SAMPLE) & (gate.y_i != and3_ref(pattern));
    assign err_nx   = err_count + {3'b000, mismatch};
    assign tmr_en   = (state == DRIVE);
    assign tmr_clr  = (state != DRIVE);

    assign gate.a_o = drive[2];
    assign gate.b_o = drive[1];
    assign gate.c_o = drive[0];

    hold_timer #(
        .CNT_W       (CNT_W),
        .HOLD_CYCLES (HOLD_CYCLES)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (tmr_clr),
        .en    (tmr_en),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (start) state_nx = DRIVE;
            DRIVE:   if (tc) state_nx = SAMPLE;
            SAMPLE:  state_nx = last ? DONE : DRIVE;
            DONE:    if (start) state_nx = DRIVE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pattern      <= '0;
            drive        <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            fail_pattern <= '0;
        end else if (accept) begin
            pattern      <= '0;
            drive        <= '0;
            busy         <= 1'b1;
            done         <= 1'b0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            fail_pattern <= '0;
        end else if (state == SAMPLE) begin
            err_count <= err_nx;
            if (mismatch && !fail_valid) begin
                fail_valid   <= 1'b1;
                fail_pattern <= pattern;
            end
            // pass uses the updated count so a pattern-7 miss is included
            if (last) begin
                busy <= 1'b0;
                done <= 1'b1;
                pass <= (err_nx == 4'd0);
            end else begin
                pattern <= pattern + 3'd1;
                drive   <= pattern + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_and3_pattern_checker.sv
// Bench for and3_pattern_checker: table of sweeps against a modelled
// gate (good, stuck-0, stuck-1, inverted) plus restart/reset sequences.
module tb_and3_pattern_checker;

    import and3_tp_pkg::*;

    typedef struct {
        bit         use1;
        int         mode;
        logic [3:0] err;
        logic       fv;
        logic [2:0] fp;
        logic       pass;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic st4 = 1'b0;
    logic st1 = 1'b0;
    int   mode = 0;
    bit   sel = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    vec_t vt[7];
    vec_t exp_q[$];

    logic       busy4, done4, pass4, fv4;
    logic [3:0] err4;
    logic [2:0] fp4;
    logic       busy1, done1, pass1, fv1;
    logic [3:0] err1;
    logic [2:0] fp1;

    logic       s_busy, s_done, s_pass, s_fv;
    logic [3:0] s_err;
    logic [2:0] s_fp, s_abc;

    and3_pattern_checker_if g4 ();
    and3_pattern_checker_if g1 ();

    always #5 clk = ~clk;

    function automatic logic gate_model(input int m, input logic [2:0] p);
        case (m)
            1:       return 1'b0;
            2:       return 1'b1;
            3:       return ~(&p);
            default: return &p;
        endcase
    endfunction

    always_comb g4.y_i = gate_model(mode, {g4.a_o, g4.b_o, g4.c_o});
    always_comb g1.y_i = gate_model(mode, {g1.a_o, g1.b_o, g1.c_o});

    and3_pattern_checker #(.HOLD_CYCLES(4), .CNT_W(8)) dut4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (st4),
        .gate         (g4),
        .busy         (busy4),
        .done         (done4),
        .pass         (pass4),
        .err_count    (err4),
        .fail_valid   (fv4),
        .fail_pattern (fp4)
    );

    and3_pattern_checker #(.HOLD_CYCLES(1), .CNT_W(8)) dut1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (st1),
        .gate         (g1),
        .busy         (busy1),
        .done         (done1),
        .pass         (pass1),
        .err_count    (err1),
        .fail_valid   (fv1),
        .fail_pattern (fp1)
    );

    always_comb begin
        s_busy = sel ? busy1 : busy4;
        s_done = sel ? done1 : done4;
        s_pass = sel ? pass1 : pass4;
        s_err  = sel ? err1 : err4;
        s_fv   = sel ? fv1 : fv4;
        s_fp   = sel ? fp1 : fp4;
        s_abc  = sel ? {g1.a_o, g1.b_o, g1.c_o}
                     : {g4.a_o, g4.b_o, g4.c_o};
    end

    task automatic chk(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic set_start(input logic v);
        if (sel) st1 = v;
        else     st4 = v;
    endtask

    // all outputs of the selected DUT packed, for reset checks
    function automatic logic [15:0] all_outs();
        return {2'b0, s_abc, s_busy, s_done, s_pass, s_err, s_fv, s_fp};
    endfunction

    task automatic run_sweep(input bit use1, input int rp_at,
                             input int rst_at);
        int   h;
        int   len;
        vec_t e;
        h   = use1 ? 1 : 4;
        len = 8 * (h + 1);
        sel = use1;
        @(negedge clk);
        set_start(1'b1);
        @(negedge clk);
        set_start(1'b0);
        for (int k = 0; k < len; k++) begin
            chk($sformatf("timeline k=%0d", k),
                {11'b0, s_busy, s_done, s_abc},
                {11'b0, 1'b1, 1'b0, 3'(k / (h + 1))});
            if (k == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_mid_sweep", all_outs(), 16'h0);
                @(negedge clk);
                rst_n = 1'b1;
                repeat (50) @(negedge clk);
                chk("idle_after_reset", {14'b0, s_busy, s_done}, 16'h0);
                return;
            end
            set_start(k == rp_at);
            @(negedge clk);
        end
        set_start(1'b0);
        e = exp_q.pop_front();
        chk("done_flags", {14'b0, s_busy, s_done}, 16'h1);
        chk("err_count", {12'b0, s_err}, {12'b0, e.err});
        chk("fail_valid", {15'b0, s_fv}, {15'b0, e.fv});
        if (e.fv) chk("fail_pattern", {13'b0, s_fp}, {13'b0, e.fp});
        chk("pass", {15'b0, s_pass}, {15'b0, e.pass});
        repeat (3) @(negedge clk);
        chk("done_frozen", {11'b0, s_busy, s_done, s_abc}, 16'h0f);
    endtask

    initial begin
        vt[0] = '{1'b0, 0, 4'd0, 1'b0, 3'd0, 1'b1};
        vt[1] = '{1'b0, 1, 4'd1, 1'b1, 3'd7, 1'b0};
        vt[2] = '{1'b0, 2, 4'd7, 1'b1, 3'd0, 1'b0};
        vt[3] = '{1'b0, 3, 4'd8, 1'b1, 3'd0, 1'b0};
        vt[4] = '{1'b0, 0, 4'd0, 1'b0, 3'd0, 1'b1};
        vt[5] = '{1'b1, 0, 4'd0, 1'b0, 3'd0, 1'b1};
        vt[6] = '{1'b1, 3, 4'd8, 1'b1, 3'd0, 1'b0};

        repeat (3) @(negedge clk);
        sel = 1'b0;
        #1;
        chk("reset_dut4", all_outs(), 16'h0);
        sel = 1'b1;
        #1;
        chk("reset_dut1", all_outs(), 16'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            mode = vt[i].mode;
            exp_q.push_back(vt[i]);
            run_sweep(vt[i].use1, -1, -1);
        end

        // start re-pulsed mid-sweep must be ignored
        mode = 0;
        exp_q.push_back('{1'b0, 0, 4'd0, 1'b0, 3'd0, 1'b1});
        run_sweep(1'b0, 10, -1);

        // reset mid-sweep, then a fresh sweep must still work
        mode = 1;
        run_sweep(1'b0, -1, 20);
        exp_q.push_back('{1'b0, 1, 4'd1, 1'b1, 3'd7, 1'b0});
        run_sweep(1'b0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
